// File: rtl/sbox_pkg.sv
// ============================================================================
// Module      : sbox_pkg
// Description : Shared S-box constants, types, affine transforms and GF(2^8)
//               multiply used by the byte-serial S-box engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sbox_pkg;

    localparam logic [7:0] SBOX_AFF_C = 8'h63;
    localparam logic [7:0] INV_AFF_C  = 8'h05;
    localparam logic [8:0] GF_POLY    = 9'h11B;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic byte_t rotl8(input byte_t x, input int unsigned n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic byte_t inv_affine(input byte_t x);
        return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ INV_AFF_C;
    endfunction

    function automatic byte_t fwd_affine(input byte_t x);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ SBOX_AFF_C;
    endfunction

    // Shift-and-add multiply with reduction by the AES field polynomial.
    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = t[7] ? ({t[6:0], 1'b0} ^ GF_POLY[7:0]) : {t[6:0], 1'b0};
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gf256_inv.sv
// ============================================================================
// Module      : gf256_inv
// Description : Combinational GF(2^8) inverse (x^254), giving inv(0)=0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gf256_inv (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import sbox_pkg::*;

    byte_t w_x2, w_x3, w_x6, w_x12, w_x14, w_x15;
    byte_t w_x30, w_x60, w_x120, w_x240;

    // Addition chain for x^254 = x^240 * x^14.
    assign w_x2   = gf_mul(a, a);
    assign w_x3   = gf_mul(w_x2, a);
    assign w_x6   = gf_mul(w_x3, w_x3);
    assign w_x12  = gf_mul(w_x6, w_x6);
    assign w_x14  = gf_mul(w_x12, w_x2);
    assign w_x15  = gf_mul(w_x12, w_x3);
    assign w_x30  = gf_mul(w_x15, w_x15);
    assign w_x60  = gf_mul(w_x30, w_x30);
    assign w_x120 = gf_mul(w_x60, w_x60);
    assign w_x240 = gf_mul(w_x120, w_x120);
    assign y      = gf_mul(w_x240, w_x14);

endmodule

`default_nettype wire

// File: rtl/inv_sbox_word_seq.sv
// ============================================================================
// Module      : inv_sbox_word_seq
// Description : Byte-serial AES inverse S-box over an NBYTES word, one byte
//               per cycle through a shared inverter, valid/ready on both sides.
//               Optional macro SBOX_FWD_EN adds a dir port (1 = forward S-box).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_sbox_word_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_data,
`ifdef SBOX_FWD_EN
    input  logic                  dir,
`endif
    output logic                  busy
);
    import sbox_pkg::*;

    localparam int             CW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0]  LAST = CW'(NBYTES - 1);

    state_t                r_state;
    state_t                w_next;
    logic [8*NBYTES-1:0]   r_src;
    logic [8*NBYTES-1:0]   r_res;
    logic [CW-1:0]         r_cnt;
    byte_t                 w_byte;
    byte_t                 w_gf_in;
    byte_t                 w_gf_out;
    byte_t                 w_sbox;
    logic                  w_accept;

    assign w_accept = (r_state == IDLE) && in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)      w_next = RUN;
            RUN:     if (r_cnt == LAST) w_next = DONE;
            DONE:    if (out_ready)     w_next = IDLE;
            default:                    w_next = IDLE;
        endcase
    end

    always_comb begin
        w_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_cnt == CW'(i)) w_byte = r_src[8*i +: 8];
        end
    end

`ifdef SBOX_FWD_EN
    logic r_dir;
    // Forward: invert then affine; inverse: affine then invert.
    assign w_gf_in = r_dir ? w_byte : inv_affine(w_byte);
    assign w_sbox  = r_dir ? fwd_affine(w_gf_out) : w_gf_out;
`else
    assign w_gf_in = inv_affine(w_byte);
    assign w_sbox  = w_gf_out;
`endif

    gf256_inv u_gf256_inv (
        .a (w_gf_in),
        .y (w_gf_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src <= '0;
            r_res <= '0;
            r_cnt <= '0;
`ifdef SBOX_FWD_EN
            r_dir <= 1'b0;
`endif
        end else if (w_accept) begin
            r_src <= in_data;
            r_res <= '0;
            r_cnt <= '0;
`ifdef SBOX_FWD_EN
            r_dir <= dir;
`endif
        end else if (r_state == RUN) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (r_cnt == CW'(i)) r_res[8*i +: 8] <= w_sbox;
            end
            if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_res;

endmodule

`default_nettype wire

// File: tb/tb_inv_sbox_word_seq.sv
// ============================================================================
// Module      : tb_inv_sbox_word_seq
// Description : Scoreboard bench for inv_sbox_word_seq against a table model
//               built from field arithmetic. Honours SBOX_FWD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inv_sbox_word_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;
    // One IDLE cycle, NB RUN cycles and one DONE cycle per word.
    localparam int PERIOD = NB + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;
`ifdef SBOX_FWD_EN
    logic          dir;
`endif

    always #5 clk = ~clk;

    inv_sbox_word_seq #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef SBOX_FWD_EN
        .dir       (dir),
`endif
        .busy      (busy)
    );

    logic [7:0]   fwd_tbl [256];
    logic [7:0]   inv_tbl [256];
    logic [W-1:0] exp_q [$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    int           last_xfer = -1;
    bit           check_period = 1'b0;

    // Carry-less product, then polynomial long division by 0x11B.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [W-1:0] inv_word(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int k = 0; k < NB; k++) r[8*k +: 8] = inv_tbl[w[8*k +: 8]];
        return r;
    endfunction

    function automatic logic [W-1:0] fwd_word(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int k = 0; k < NB; k++) r[8*k +: 8] = fwd_tbl[w[8*k +: 8]];
        return r;
    endfunction

    task automatic check_word(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a transfer completes at the next edge when valid and ready are seen here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none", out_data);
            end else begin
                check_word("out_data", out_data, exp_q.pop_front());
            end
            if (check_period && last_xfer >= 0) check_int("throughput_period", cyc - last_xfer, PERIOD);
            last_xfer = cyc;
        end
    end

    // Starts and ends at posedge+1; pushes the expectation when acceptance is due.
    task automatic send(input logic [W-1:0] d, input logic [W-1:0] e);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_bit("accept_timeout", acc, 1'b1);
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && (exp_q.size() != 0 || busy); t++) begin
            @(posedge clk);
            #1;
        end
        check_int("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]   b, s, c;
        logic [W-1:0] w, d, f;
        bit           seen;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef SBOX_FWD_EN
        dir = 1'b0;
`endif
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            b = 8'h00;
            for (int y = 1; y < 256; y++) if (ref_mul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
            fwd_tbl[x] = s;
            inv_tbl[s] = 8'(x);
        end

        // Reset state
        @(negedge clk);
        check_bit("rst_in_ready", in_ready, 1'b1);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_word("rst_out_data", out_data, '0);
        @(posedge clk); #1; rst = 1'b0;

        // Single word with latency and busy profile
        send(32'h7B777C63, 32'h03020100);
        for (int k = 0; k <= NB; k++) begin
            @(negedge clk);
            check_bit("busy_run", busy, 1'b1);
            check_bit("out_valid_latency", out_valid, k == NB);
        end
        check_word("tv1_data", out_data, 32'h03020100);
        @(posedge clk); #1; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("idle_after_xfer_ready", in_ready, 1'b1);
        check_bit("idle_after_xfer_busy", busy, 1'b0);
        @(posedge clk); #1;

        // Boundary bytes
        send(32'h16005263, 32'hFF524800);
        drain();

        // Backpressure with ignored input
        out_ready = 1'b0;
        w = $urandom;
        send(w, inv_word(w));
        seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
        end
        check_bit("bp_valid_seen", seen, 1'b1);
        in_valid = 1'b1;
        in_data  = ~w;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            check_bit("bp_out_valid", out_valid, 1'b1);
            check_word("bp_out_data", out_data, inv_word(w));
            check_bit("bp_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_bit("bp_release_in_ready", in_ready, 1'b1);
        check_bit("bp_release_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        drain();

        // Reset during RUN while cnt==2 discards the partial word
        send(32'h1234A5C3, inv_word(32'h1234A5C3));
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_bit("midrst_out_valid", out_valid, 1'b0);
        check_bit("midrst_in_ready", in_ready, 1'b1);
        check_bit("midrst_busy", busy, 1'b0);
        check_word("midrst_out_data", out_data, '0);
        void'(exp_q.pop_back());
        @(posedge clk); #1; rst = 1'b0;
        w = $urandom;
        send(w, inv_word(w));
        drain();

        // Random words back-to-back
        for (int n = 0; n < 30; n++) begin
            w = $urandom;
            send(w, inv_word(w));
        end
        drain();

        // Every byte value in every lane, with throughput checked
        check_period = 1'b1;
        last_xfer    = -1;
        for (int j = 0; j < 256; j++) begin
            for (int k = 0; k < NB; k++) d[8*k +: 8] = 8'(j + 37 * k);
            send(d, inv_word(d));
        end
        drain();
        check_period = 1'b0;

`ifdef SBOX_FWD_EN
        dir = 1'b1;
        send(32'h03020100, 32'h7B777C63);
        drain();
        w = $urandom;
        f = fwd_word(w);
        send(w, f);
        drain();
        dir = 1'b0;
        send(f, w);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
